// File: rtl/redux_pkg.sv
// Shared widths and FSM state encoding for the memory-copy DMA.
package redux_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/data_memory.sv
// Byte-wide data memory: combinational read, clocked write.
module data_memory #(
   parameter int ADDR_W = redux_pkg::ADDR_W,
   parameter int DATA_W = redux_pkg::DATA_W
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   input  logic              write_enable,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // write port; contents are not touched by reset
   always_ff @(posedge clk) begin
      if (write_enable) mem[address] <= data_in;
   end

   assign data_out = mem[address];

endmodule

// File: rtl/mem_copy_dma.sv
// Single-byte-at-a-time forward memory copy engine.
// Each byte takes a READ cycle (address src+i, capture) and a WRITE
// cycle (address dst+i, strobe), followed by a one-cycle DONE pulse.
module mem_copy_dma #(
   parameter int ADDR_W = redux_pkg::ADDR_W,
   parameter int DATA_W = redux_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_write_enable,
   input  logic [DATA_W-1:0] mem_data_in
);

   import redux_pkg::*;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] src_q, dst_q, len_q, idx;
   logic [DATA_W-1:0] buf_q;
   logic              last;

   // last byte of the transfer is being written
   assign last = (idx == len_q - ADDR_W'(1));

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // latched request, byte index and byte buffer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         src_q <= '0;
         dst_q <= '0;
         len_q <= '0;
         idx   <= '0;
         buf_q <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               src_q <= src_addr;
               dst_q <= dst_addr;
               len_q <= length;
               idx   <= '0;
            end
            READ:  buf_q <= mem_data_in;
            WRITE: if (!last) idx <= idx + ADDR_W'(1);
            default: ;
         endcase
      end
   end

   // next state and Moore outputs; addresses wrap modulo 2^ADDR_W
   always_comb begin
      state_nxt        = state;
      busy             = 1'b0;
      done             = 1'b0;
      mem_address      = '0;
      mem_data_out     = '0;
      mem_write_enable = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (length == '0) ? DONE : READ;
         end
         READ: begin
            busy        = 1'b1;
            mem_address = src_q + idx;
            state_nxt   = WRITE;
         end
         WRITE: begin
            busy             = 1'b1;
            mem_address      = dst_q + idx;
            mem_data_out     = buf_q;
            mem_write_enable = 1'b1;
            state_nxt        = last ? DONE : READ;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma paired with data_memory.
module tb_mem_copy_dma;

   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] src_addr, dst_addr, length;
   logic          busy, done, mem_write_enable;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_out, mem_rd;

   // bench-side access to the memory for preload and readback
   logic          tb_sel, tb_we;
   logic [AW-1:0] tb_addr;
   logic [DW-1:0] tb_din;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_din;
   logic          m_we;

   int checks   = 0;
   int failures = 0;

   assign m_addr = tb_sel ? tb_addr : mem_address;
   assign m_din  = tb_sel ? tb_din  : mem_data_out;
   assign m_we   = tb_sel ? tb_we   : mem_write_enable;

   always #5 clk = ~clk;

   mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .busy(busy), .done(done),
      .mem_address(mem_address), .mem_data_out(mem_data_out),
      .mem_write_enable(mem_write_enable), .mem_data_in(mem_rd)
   );

   data_memory #(.ADDR_W(AW), .DATA_W(DW)) u_mem (
      .clk(clk), .address(m_addr), .data_in(m_din),
      .write_enable(m_we), .data_out(mem_rd)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mt = cycles since the start edge (0 = idle). A copy of L bytes spends
   // cycles 1..2L alternating read/write, then done at cycle 2L+1.
   logic [7:0] mmem [256];
   int mt = 0, ms = 0, md = 0, ml = 0;

   always @(posedge clk or negedge reset) begin
      if (tb_sel && tb_we) mmem[tb_addr] <= tb_din;
      if (!reset) mt <= 0;
      else if (mt == 0) begin
         if (start) begin
            ms <= int'(src_addr); md <= int'(dst_addr); ml <= int'(length); mt <= 1;
         end
      end else if (mt >= 2*ml + 1) mt <= 0;
      else begin
         if (mt % 2 == 0) mmem[(md + mt/2 - 1) % 256] <= mmem[(ms + mt/2 - 1) % 256];
         mt <= mt + 1;
      end
   end

   // per-cycle output comparison against the model
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (mt == 0) begin
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_we",   32'(mem_write_enable), 0);
            chk("idle_addr", 32'(mem_address), 0);
            chk("idle_dout", 32'(mem_data_out), 0);
         end else if (mt == 2*ml + 1) begin
            chk("done_done", 32'(done), 1);
            chk("done_busy", 32'(busy), 0);
            chk("done_we",   32'(mem_write_enable), 0);
            chk("done_addr", 32'(mem_address), 0);
            chk("done_dout", 32'(mem_data_out), 0);
         end else if (mt % 2 == 1) begin
            chk("rd_busy", 32'(busy), 1);
            chk("rd_done", 32'(done), 0);
            chk("rd_we",   32'(mem_write_enable), 0);
            chk("rd_addr", 32'(mem_address), 32'((ms + (mt-1)/2) % 256));
         end else begin
            chk("wr_busy", 32'(busy), 1);
            chk("wr_done", 32'(done), 0);
            chk("wr_we",   32'(mem_write_enable), 1);
            chk("wr_addr", 32'(mem_address), 32'((md + mt/2 - 1) % 256));
            chk("wr_data", 32'(mem_data_out), 32'(mmem[(ms + mt/2 - 1) % 256]));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_sel = 1'b1; tb_addr = a; tb_din = d; tb_we = 1'b1;
      @(posedge clk);
      #1 tb_we = 1'b0; tb_sel = 1'b0;
   endtask

   task automatic chk_mem(input string name, input logic [7:0] a, input logic [7:0] lit);
      @(negedge clk);
      #1 tb_sel = 1'b1; tb_addr = a;
      #1;
      chk(name, 32'(mem_rd), 32'(lit));
      chk({name, "_mdl"}, 32'(mem_rd), 32'(mmem[a]));
      tb_sel = 1'b0;
   endtask

   task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input bit repulse, input int abort_at, input bit rel,
                           output int dn, output int ws, output int dc, output bit bz);
      int n;
      @(negedge clk);
      if (rel) reset = 1'b1;
      src_addr = s; dst_addr = d; length = l; start = 1'b1;
      @(posedge clk);
      n = 0; dn = 0; ws = 0; dc = 0; bz = 1'b0;
      while (n < 600) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (repulse && n == 3) start = 1'b1;
         if (repulse && n == 4) start = 1'b0;
         if (busy) bz = 1'b1;
         if (mem_write_enable) ws++;
         if (done) begin dc++; if (dn == 0) dn = n; end
         if (abort_at != 0 && n == abort_at) begin
            #1 reset = 1'b0;
            #1;
            chk("abort_busy", 32'(busy), 0);
            chk("abort_done", 32'(done), 0);
            chk("abort_we",   32'(mem_write_enable), 0);
            chk("abort_addr", 32'(mem_address), 0);
            chk("abort_dout", 32'(mem_data_out), 0);
            break;
         end
         if (dn != 0 && n >= dn + 3) break;
      end
      if (abort_at == 0 && dn == 0) chk("done_timeout", 0, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int dn, ws, dc;
      bit bz;
      reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
      tb_sel = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_din = '0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_we",   32'(mem_write_enable), 0);
      chk("rst_addr", 32'(mem_address), 0);
      reset = 1'b1;

      // basic 4-byte copy
      poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC); poke(8'h13, 8'hDD);
      run_copy(8'h10, 8'h80, 8'd4, 1'b0, 0, 1'b0, dn, ws, dc, bz);
      chk("c1_done_cycle", 32'(dn), 9);
      chk("c1_strobes", 32'(ws), 4);
      chk("c1_done_pulses", 32'(dc), 1);
      chk_mem("c1_m80", 8'h80, 8'hAA);
      chk_mem("c1_m81", 8'h81, 8'hBB);
      chk_mem("c1_m82", 8'h82, 8'hCC);
      chk_mem("c1_m83", 8'h83, 8'hDD);

      // zero-length copy
      run_copy(8'h30, 8'h31, 8'd0, 1'b0, 0, 1'b0, dn, ws, dc, bz);
      chk("z_done_cycle", 32'(dn), 1);
      chk("z_busy_seen", 32'(bz), 0);
      chk("z_strobes", 32'(ws), 0);

      // address wrap
      poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33); poke(8'h01, 8'h22);
      for (int a = 2; a < 6; a++) poke(8'(a), 8'h00);
      run_copy(8'hFE, 8'h02, 8'd4, 1'b0, 0, 1'b0, dn, ws, dc, bz);
      chk("w_done_cycle", 32'(dn), 9);
      chk_mem("w_m02", 8'h02, 8'h11);
      chk_mem("w_m03", 8'h03, 8'h22);
      chk_mem("w_m04", 8'h04, 8'h33);
      chk_mem("w_m05", 8'h05, 8'h22);

      // start pulsed while busy is ignored
      poke(8'h50, 8'h01); poke(8'h51, 8'h02); poke(8'h52, 8'h03);
      run_copy(8'h50, 8'h60, 8'd3, 1'b1, 0, 1'b0, dn, ws, dc, bz);
      chk("rp_done_cycle", 32'(dn), 7);
      chk("rp_done_pulses", 32'(dc), 1);
      chk("rp_strobes", 32'(ws), 3);
      chk_mem("rp_m62", 8'h62, 8'h03);

      // reset in the middle of an 8-byte copy
      for (int k = 0; k < 8; k++) begin
         poke(8'(8'h40 + k), 8'(8'hA0 + k));
         poke(8'(8'h90 + k), 8'hEE);
      end
      run_copy(8'h40, 8'h90, 8'd8, 1'b0, 5, 1'b0, dn, ws, dc, bz);
      chk("ab_done_pulses", 32'(dc), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("ab_no_done", 32'(done), 0);
      end
      chk_mem("ab_m90", 8'h90, 8'hA0);
      chk_mem("ab_m91", 8'h91, 8'hA1);
      chk_mem("ab_m92", 8'h92, 8'hEE);
      chk_mem("ab_m97", 8'h97, 8'hEE);

      // overlapping forward copy, started on the first edge after reset release
      poke(8'h20, 8'h5A); poke(8'h21, 8'h00); poke(8'h22, 8'h00); poke(8'h23, 8'h00);
      run_copy(8'h20, 8'h21, 8'd3, 1'b0, 0, 1'b1, dn, ws, dc, bz);
      chk("ov_done_cycle", 32'(dn), 7);
      chk_mem("ov_m21", 8'h21, 8'h5A);
      chk_mem("ov_m22", 8'h22, 8'h5A);
      chk_mem("ov_m23", 8'h23, 8'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
